// File: rtl/prog_sequencer.sv
// Program sequencer: launches up to three fetch programs in rotation, holds
// the fetch stage while idle, loading or draining, counts run cycles and
// terminates a runaway program after TIMEOUT_LIMIT cycles.
module prog_sequencer #(
    parameter logic [9:0]  PROG0_BASE    = 10'd0,
    parameter logic [9:0]  PROG1_BASE    = 10'd128,
    parameter logic [9:0]  PROG2_BASE    = 10'd256,
    parameter int          DRAIN_CYCLES  = 2,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'd4096
) (
    input  logic        CLK,
    input  logic        Init,
    input  logic        Start,
    input  logic        Halt,
    output logic        FetchHold,
    output logic        PcLoad,
    output logic [9:0]  PcLoadVal,
    output logic [1:0]  ProgState,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] CycleCount,
    output logic        Timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // A limit of zero means "no explicit limit": saturate at 65535 instead.
    localparam logic [15:0] RUN_LAST   = (TIMEOUT_LIMIT == 16'd0) ? 16'hFFFE
                                                                  : TIMEOUT_LIMIT - 16'd1;
    localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;

    // Start address of the selected program; index 3 is unused and aliases program 0.
    always_comb begin
        PcLoadVal = PROG0_BASE;
        case (ProgState)
            2'd1:    PcLoadVal = PROG1_BASE;
            2'd2:    PcLoadVal = PROG2_BASE;
            default: PcLoadVal = PROG0_BASE;
        endcase
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge CLK) begin
        if (Init) begin
            state      <= S_IDLE;
            FetchHold  <= 1'b1;
            PcLoad     <= 1'b0;
            ProgState  <= 2'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            CycleCount <= 16'd0;
            Timeout    <= 1'b0;
            drain_cnt  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state      <= S_LOAD;
                        PcLoad     <= 1'b1;
                        FetchHold  <= 1'b1;
                        Busy       <= 1'b1;
                        CycleCount <= 16'd0;
                        Timeout    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state     <= S_RUN;
                    PcLoad    <= 1'b0;
                    FetchHold <= 1'b0;
                end
                S_RUN: begin
                    // The halt cycle itself is counted; halt beats timeout.
                    CycleCount <= CycleCount + 16'd1;
                    if (Halt) begin
                        state     <= S_DRAIN;
                        FetchHold <= 1'b1;
                        drain_cnt <= 4'd0;
                    end else if (CycleCount == RUN_LAST) begin
                        state     <= S_DRAIN;
                        FetchHold <= 1'b1;
                        Timeout   <= 1'b1;
                        drain_cnt <= 4'd0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        drain_cnt <= 4'd0;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        state      <= S_LOAD;
                        ProgState  <= (ProgState == 2'd2) ? 2'd0 : ProgState + 2'd1;
                        PcLoad     <= 1'b1;
                        Busy       <= 1'b1;
                        Done       <= 1'b0;
                        CycleCount <= 16'd0;
                        Timeout    <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    FetchHold <= 1'b1;
                    PcLoad    <= 1'b0;
                    Busy      <= 1'b0;
                    Done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: launch/halt rounds, program rotation,
// timeout boundary, mid-run reset and ignored-input cases.
module tb_prog_sequencer;

    localparam int DRAIN = 2;
    localparam int TLIM  = 4096;

    logic        CLK = 1'b0;
    logic        Init, Start, Halt;
    logic        FetchHold, PcLoad, Busy, Done, Timeout;
    logic [9:0]  PcLoadVal;
    logic [1:0]  ProgState;
    logic [15:0] CycleCount;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    prog_sequencer dut (
        .CLK(CLK), .Init(Init), .Start(Start), .Halt(Halt),
        .FetchHold(FetchHold), .PcLoad(PcLoad), .PcLoadVal(PcLoadVal),
        .ProgState(ProgState), .Busy(Busy), .Done(Done),
        .CycleCount(CycleCount), .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_of(input int p);
        case (p)
            1:       return 128;
            2:       return 256;
            default: return 0;
        endcase
    endfunction

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    // One-cycle Start from IDLE/DONE; leaves the DUT in its first RUN cycle.
    task automatic launch(input int prog, input bit hold_start);
        exp_q.push_back(base_of(prog));
        exp_q.push_back(prog);
        Start = 1'b1;
        tick();
        if (!hold_start) Start = 1'b0;
        chk("load_pcload",   32'(PcLoad),    1);
        chk("load_pcval",    32'(PcLoadVal), pop_exp());
        chk("load_prog",     32'(ProgState), pop_exp());
        chk("load_hold",     32'(FetchHold), 1);
        chk("load_busy",     32'(Busy),      1);
        chk("load_cnt",      32'(CycleCount), 0);
        tick();
        chk("run_hold",      32'(FetchHold), 0);
        chk("run_busy",      32'(Busy),      1);
        chk("run_pcload",    32'(PcLoad),    0);
    endtask

    // Called on the first DRAIN cycle; walks the drain and checks DONE.
    task automatic drain_done(input int exp_cnt, input int exp_to);
        exp_q.push_back(exp_cnt);
        exp_q.push_back(exp_to);
        for (int i = 0; i < DRAIN; i++) begin
            chk("drain_hold", 32'(FetchHold), 1);
            chk("drain_busy", 32'(Busy),      1);
            chk("drain_done", 32'(Done),      0);
            if (i == DRAIN - 1) Start = 1'b0;
            tick();
        end
        chk("done_flag",    32'(Done),       1);
        chk("done_busy",    32'(Busy),       0);
        chk("done_hold",    32'(FetchHold),  1);
        chk("done_cnt",     32'(CycleCount), pop_exp());
        chk("done_timeout", 32'(Timeout),    pop_exp());
    endtask

    // From the first RUN cycle, assert Halt on RUN cycle n.
    task automatic run_halt(input int n);
        repeat (n - 1) tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
    endtask

    initial begin
        Init = 1'b1; Start = 1'b0; Halt = 1'b0;
        tick(); tick();
        chk("rst_hold",    32'(FetchHold),  1);
        chk("rst_pcload",  32'(PcLoad),     0);
        chk("rst_prog",    32'(ProgState),  0);
        chk("rst_busy",    32'(Busy),       0);
        chk("rst_done",    32'(Done),       0);
        chk("rst_cnt",     32'(CycleCount), 0);
        chk("rst_timeout", 32'(Timeout),    0);

        // Stay idle without Start; Halt in IDLE is ignored.
        Init = 1'b0;
        tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
        chk("idle_busy",   32'(Busy),      0);
        chk("idle_pcload", 32'(PcLoad),    0);
        chk("idle_hold",   32'(FetchHold), 1);

        // Round 1: program 0, halt on 10th run cycle.
        launch(0, 1'b0);
        run_halt(10);
        drain_done(10, 0);

        // Halt in DONE is ignored.
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
        chk("done_halt_flag", 32'(Done),       1);
        chk("done_halt_cnt",  32'(CycleCount), 10);

        // Round 2: program 1 with Start held through RUN and DRAIN.
        launch(1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("hold_start_norelaunch", 32'(PcLoad),    0);
            chk("hold_start_running",    32'(FetchHold), 0);
        end
        run_halt(1);
        drain_done(7, 0);
        tick();
        chk("done_stays", 32'(Done), 1);

        // Round 3: program 2, then wrap back to program 0.
        launch(2, 1'b0);
        run_halt(5);
        drain_done(5, 0);

        // Round 4: program 0 runs into the timeout.
        launch(0, 1'b0);
        repeat (TLIM - 1) tick();
        chk("pre_to_cnt",  32'(CycleCount), TLIM - 1);
        chk("pre_to_flag", 32'(Timeout),    0);
        tick();
        chk("to_cnt",  32'(CycleCount), TLIM);
        chk("to_flag", 32'(Timeout),    1);
        drain_done(TLIM, 1);

        // Round 5: program 1, reset after 50 run cycles with Start/Halt also high.
        launch(1, 1'b0);
        repeat (50) tick();
        chk("mid_cnt",  32'(CycleCount), 50);
        chk("mid_prog", 32'(ProgState),  1);
        Init = 1'b1; Start = 1'b1; Halt = 1'b1;
        tick();
        Init = 1'b0; Start = 1'b0; Halt = 1'b0;
        chk("init_prog",  32'(ProgState),  0);
        chk("init_cnt",   32'(CycleCount), 0);
        chk("init_hold",  32'(FetchHold),  1);
        chk("init_busy",  32'(Busy),       0);
        chk("init_load",  32'(PcLoad),     0);
        tick();
        chk("init_idle",  32'(Busy),       0);

        // Round 6: halt on exactly the limit cycle beats the timeout.
        launch(0, 1'b0);
        run_halt(TLIM);
        drain_done(TLIM, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
